// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with clear sweep
//
// Register file for the MIPS datapath: two write ports (w0 for ALU results,
// w1 for load results), NUM_RD combinational read ports, register 0
// hard-wired to zero. Synchronous reset starts a hardware sweep that zeroes
// every entry; busy is high while the sweep runs.
//
// Optional feature macro: REGFILE_BYPASS_EN
//    defined   - a read of an address being written in the same cycle returns
//                the write data combinationally (w1 preferred over w0).
//    undefined - reads return the array contents; new data visible next cycle.
//
// Ports:
//    clk      clock, all state updates on the rising edge
//    rst      synchronous active-high reset, restarts the clear sweep
//    w0_ena   write port 0 enable
//    w0_addr  write port 0 address
//    w0_data  write port 0 data
//    w1_ena   write port 1 enable (wins over w0 on an address conflict)
//    w1_addr  write port 1 address
//    w1_data  write port 1 data
//    r_addr   flattened read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//    r_data   flattened read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//    busy     clear sweep in progress; writes dropped and reads return 0

module regfile_mp #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         w0_ena,
   input  logic [ADDR_WIDTH-1:0]        w0_addr,
   input  logic [DATA_WIDTH-1:0]        w0_data,
   input  logic                         w1_ena,
   input  logic [ADDR_WIDTH-1:0]        w1_addr,
   input  logic [DATA_WIDTH-1:0]        w1_data,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
   output logic                         busy
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] clr_ptr;
   logic [ADDR_WIDTH-1:0] clr_ptr_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  w0_commit;
   logic                  w1_commit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   // The pointer wraps DEPTH-1 -> 0 on the same edge the sweep ends, so it
   // rests at 0 in RUN without a separate clear.
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      busy        = 1'b0;
      case (state)
         CLEAR: begin
            busy        = 1'b1;
            clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
            if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = CLEAR;
         end
      endcase
   end

   assign w0_commit = w0_ena && (w0_addr != '0) && !busy;
   assign w1_commit = w1_ena && (w1_addr != '0) && !busy;

   // Array update: sweep entry in CLEAR, port writes in RUN. On a same-address
   // conflict w0 is suppressed so w1 lands alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
         end else begin
            if (w0_commit && !(w1_commit && (w1_addr == w0_addr))) begin
               mem[w0_addr] <= w0_data;
            end
            if (w1_commit) begin
               mem[w1_addr] <= w1_data;
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;

      assign addr = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         data = '0;
         if (!busy && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (w1_ena && (w1_addr == addr)) begin
               data = w1_data;
            end else if (w0_ena && (w0_addr == addr)) begin
               data = w0_data;
            end else begin
               data = mem[addr];
            end
`else
            data = mem[addr];
`endif
         end
      end

      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp

module tb_regfile_mp;

   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int NR    = 3;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             w0_ena;
   logic [AW-1:0]    w0_addr;
   logic [DW-1:0]    w0_data;
   logic             w1_ena;
   logic [AW-1:0]    w1_addr;
   logic [DW-1:0]    w1_data;
   logic [NR*AW-1:0] r_addr;
   logic [NR*DW-1:0] r_data;
   logic             busy;

   int total = 0;
   int bad   = 0;

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
      .clk     (clk),
      .rst     (rst),
      .w0_ena  (w0_ena),
      .w0_addr (w0_addr),
      .w0_data (w0_data),
      .w1_ena  (w1_ena),
      .w1_addr (w1_addr),
      .w1_data (w1_data),
      .r_addr  (r_addr),
      .r_data  (r_data),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: sweep is a countdown of cycles left; its only lasting
   // effect is that every register is zero when it ends.
   logic [DW-1:0] mm [DEPTH];
   int            remaining   = 0;
   bit            model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         remaining   <= DEPTH;
         model_valid <= 1'b1;
      end else if (remaining > 0) begin
         remaining <= remaining - 1;
         if (remaining == 1) begin
            foreach (mm[i]) mm[i] <= '0;
         end
      end else begin
         if (w0_ena && w0_addr != 0) mm[w0_addr] <= w0_data;
         if (w1_ena && w1_addr != 0) mm[w1_addr] <= w1_data;
      end
   end

   function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
      if (remaining > 0) return '0;
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (w1_ena && w1_addr == a) return w1_data;
      if (w0_ena && w0_addr == a) return w0_data;
`endif
      return mm[a];
   endfunction

   task automatic chk(string name, logic [NR*DW-1:0] act, logic [NR*DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdp(int k);
      return r_data[k*DW +: DW];
   endfunction

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("busy", {{(NR*DW-1){1'b0}}, busy}, {{(NR*DW-1){1'b0}}, (remaining > 0)});
         for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_p%0d_a%0d", k, r_addr[k*AW +: AW]),
                {{((NR-1)*DW){1'b0}}, rdp(k)},
                {{((NR-1)*DW){1'b0}}, exp_rd(r_addr[k*AW +: AW])});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rd3(logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2);
      r_addr = {a2, a1, a0};
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         chk("busy_rd_zero", r_data, '0);
         n++;
      end
   endtask

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   int n;

   initial begin
      rst = 1'b1;
      w0_ena = 1'b0; w0_addr = '0; w0_data = '0;
      w1_ena = 1'b0; w1_addr = '0; w1_data = '0;
      r_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      count_busy(n);
      chk("sweep_len", NR*DW'(n), NR*DW'(32));

      for (int a = 0; a < DEPTH; a += NR) begin
         cyc();
         rd3(AW'(a), AW'((a + 1) % DEPTH), AW'((a + 2) % DEPTH));
         @(negedge clk);
         chk("post_sweep_zero", r_data, '0);
      end

      // Two writes on different ports, read back together.
      cyc(); w0_ena = 1; w0_addr = 5; w0_data = 16'hA5A5;
      cyc(); w0_ena = 0; w1_ena = 1; w1_addr = 9; w1_data = 16'h1234;
      cyc(); w1_ena = 0; rd3(5, 9, 0);
      @(negedge clk);
      chk("wr_p0", {32'h0, rdp(0)}, {32'h0, 16'hA5A5});
      chk("wr_p1", {32'h0, rdp(1)}, {32'h0, 16'h1234});
      chk("model_a5", {32'h0, mm[5]}, {32'h0, 16'hA5A5});

      // Same-address conflict, then different addresses.
      cyc(); w0_ena = 1; w0_addr = 7; w0_data = 16'h1111;
             w1_ena = 1; w1_addr = 7; w1_data = 16'h2222;
      cyc(); w0_ena = 0; w1_ena = 0; rd3(7, 7, 7);
      @(negedge clk);
      chk("conflict_w1", {32'h0, rdp(0)}, {32'h0, 16'h2222});
      chk("conflict_p2", {32'h0, rdp(2)}, {32'h0, 16'h2222});
      cyc(); w0_ena = 1; w0_addr = 3; w0_data = 16'h3333;
             w1_ena = 1; w1_addr = 4; w1_data = 16'h4444;
      cyc(); w0_ena = 0; w1_ena = 0; rd3(3, 4, 0);
      @(negedge clk);
      chk("dual_w0", {32'h0, rdp(0)}, {32'h0, 16'h3333});
      chk("dual_w1", {32'h0, rdp(1)}, {32'h0, 16'h4444});

      // Register 0 stays zero.
      cyc(); w0_ena = 1; w0_addr = 0; w0_data = 16'hFFFF;
             w1_ena = 1; w1_addr = 0; w1_data = 16'hFFFF; rd3(0, 0, 0);
      @(negedge clk);
      chk("r0_same", r_data, '0);
      cyc(); w0_ena = 0; w1_ena = 0;
      @(negedge clk);
      chk("r0_after", r_data, '0);

      // Same-cycle write/read of address 12.
      cyc(); w0_ena = 1; w0_addr = 12; w0_data = 16'h0001;
      cyc(); w0_data = 16'h00FF; rd3(12, 0, 0);
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same", {32'h0, rdp(0)}, {32'h0, 16'h00FF});
`else
      chk("bypass_same", {32'h0, rdp(0)}, {32'h0, 16'h0001});
`endif
      cyc(); w0_ena = 0;
      @(negedge clk);
      chk("bypass_next", {32'h0, rdp(0)}, {32'h0, 16'h00FF});

      // Reset mid-sweep restarts the full count; writes during busy dropped.
      cyc(); rst = 1;
      cyc(); rst = 0;
      for (int i = 0; i < 9; i++) cyc();
      rst = 1;
      cyc(); rst = 0; w0_ena = 1; w0_addr = 6; w0_data = 16'h5555; rd3(6, 6, 6);
      count_busy(n);
      #1 w0_ena = 0;
      chk("restart_len", NR*DW'(n), NR*DW'(32));
      cyc();
      @(negedge clk);
      chk("drop_busy_wr", {32'h0, rdp(0)}, '0);
      chk("model_a6", {32'h0, mm[6]}, '0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         cyc();
         rst     = ($urandom_range(0, 399) == 0);
         w0_ena  = $urandom_range(0, 1) == 1;
         w0_addr = pick();
         w0_data = DW'($urandom);
         w1_ena  = $urandom_range(0, 1) == 1;
         w1_addr = pick();
         w1_data = DW'($urandom);
         rd3(pick(), pick(), pick());
      end
      cyc();
      rst = 0; w0_ena = 0; w1_ena = 0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
